uart_flow_ctrl_hd: RTL and testbench
====================================

Name: uart_flow_ctrl_hd

Overview:
Parametrised RTS/CTS flow-control unit for the UART, successor to the basic flow controller.
- Adds a CTS synchroniser, RX-FIFO watermark RTS with hysteresis, and a half-duplex direction FSM with a turnaround guard.
- Adds a CTS-blocked timeout and a hardware flow-control bypass.
- Sits between the UART pins (rts_n/cts_n) and the TX/RX engines. Mode comes from uart_config_i (Config_t: mode, master).

Parameters:
FIFO_DEPTH, 16, RX FIFO depth; LVL_W = $clog2(FIFO_DEPTH+1)
RTS_HI_WM, 12, RX level at or above which remote is stopped (rts_n high); must be > RTS_LO_WM
RTS_LO_WM, 4, RX level at or below which remote is released again
SYNC_STAGES, 2, CTS synchroniser depth (>=2)
TURN_CYC, 16, half-duplex turnaround guard in tck cycles (>=1)
CTS_TIMEOUT, 65535, cycles of blocked TX before timeout pulse; 0 disables; TO_W = $clog2(CTS_TIMEOUT+1)

Ports:
tck  in  1  clock
rst  in  1  synchronous reset, active high
cts_n_i  in  1  CTS pin, asynchronous, active low
rts_n_o  out  1  RTS pin, active low, registered
rx_level_i  in  LVL_W  RX FIFO fill level
rx_busy_i  in  1  RX engine receiving a frame
tx_req_i  in  1  TX engine has data to send
tx_busy_i  in  1  TX frame in flight
tx_grant_o  out  1  TX may launch a new frame
tx_enable_o  out  1  TX driver enable
rx_enable_o  out  1  RX receiver enable
hwfc_en_i  in  1  1 = honour RTS/CTS, 0 = bypass
cts_timeout_o  out  1  one-cycle pulse: TX blocked CTS_TIMEOUT cycles
uart_config_i  in  Config_t  mode (FULLDUPLEX/HALFDUPLEX/SIMPLEX), master

Behaviour:
- Single clock tck. rst is synchronous, active high.
- Reset: rts_n_o=1, tx_grant_o=0, tx_enable_o=0, rx_enable_o=0, cts_timeout_o=0. Synchroniser flops=1, rx_stop=0, FSM=HD_IDLE, counters=0.
- All outputs are registered. Output value in cycle n+1 reflects inputs in cycle n; cts_n_i additionally sees SYNC_STAGES cycles of delay (cts_s).
- rx_stop hysteresis:
  - Next = 1 if rx_level_i>=RTS_HI_WM.
  - Next = 0 if rx_level_i<=RTS_LO_WM.
  - Otherwise holds.
  - RTS uses the next-state value, so there is one cycle from level to pin.
- cts_ok = !hwfc_en_i | !cts_s. With hwfc_en_i=0, rx_stop is ignored (rts_n_o=0 wherever it would follow rx_stop).
- FULLDUPLEX:
  - tx_enable=1, rx_enable=1.
  - rts_n=rx_stop.
  - tx_grant=tx_req_i & cts_ok.
  - The grant only gates frame launch; a frame in flight always completes even if CTS drops.
- SIMPLEX master: tx_enable=1, rx_enable=0, rts_n=1, tx_grant=tx_req_i & cts_ok.
- SIMPLEX slave: tx_enable=0, rx_enable=1, rts_n=rx_stop, tx_grant=0.
- HALFDUPLEX FSM (FCHdState_t):
  - HD_IDLE: rx_en=1, tx_en=0, rts_n=1. If rx_busy_i go to HD_RX; else if tx_req_i go to HD_REQ. If both, RX wins.
  - HD_REQ: rts_n=0, rx_en=1. If rx_busy_i, go to HD_RX (collision, remote wins, rts_n released). Else if cts_ok go to HD_TX. Else if tx_req_i drops, go to HD_IDLE.
  - HD_TX: tx_en=1, rx_en=0, rts_n=0, tx_grant=tx_req_i & cts_ok. When !tx_req_i & !tx_busy_i, go to HD_TURN.
  - HD_RX: rx_en=1, tx_en=0, rts_n=rx_stop. When !rx_busy_i, go to HD_TURN.
  - HD_TURN: tx_en=0, rx_en=0, rts_n=1, grant=0. Counts TURN_CYC cycles, then goes to HD_IDLE. rx_busy_i and tx_req_i are ignored while counting.
- In non-HALFDUPLEX modes the FSM is held in HD_IDLE. A mode change while the FSM is not idle forces HD_IDLE next cycle, with outputs taken from the new mode.
- Timeout counter:
  - Increments while tx_req_i & !cts_ok in a TX-capable context (FD, SIMPLEX master, HD_REQ, HD_TX); clears otherwise.
  - On reaching CTS_TIMEOUT: pulses cts_timeout_o for one cycle, clears, and restarts.
  - Saturation is impossible by sizing. CTS_TIMEOUT=0 means the counter stays 0 and there is no pulse.
- rst mid-frame: all outputs return to their reset values next edge; the TX/RX engines are reset by the same rst.

Decomposition:
- uart_defs gains FCHdState_t (HD_IDLE, HD_REQ, HD_TX, HD_RX, HD_TURN) and the default watermark/turnaround constants.
- Sub-module uart_sync: generic SYNC_STAGES-deep single-bit synchroniser with reset value parameter (1 here). It is reused for the RX pin.

Test Plan:
- FD, hwfc=1, tx_req=1: cts_n_i falls at cycle 0 -> tx_grant_o=1 at cycle 3 (SYNC_STAGES=2). cts_n_i rises -> grant=0 three cycles later; tx_busy frame not aborted.
- FD watermark: rx_level 11 -> 12: rts_n_o 0 -> 1 next cycle. Level 5: stays 1. Level 4: returns to 0. Level 12 -> 8: stays 1 (hysteresis).
- HD, tx_req=1, cts low: sequence IDLE -> REQ -> TX (tx_en=1, rx_en=0). Drop tx_req/tx_busy -> TURN: all enables 0 for exactly 16 cycles, then rx_en=1.
- HD collision: in HD_REQ raise rx_busy_i -> next cycle rts_n_o=1, rx_en=1, tx_grant=0. rx_busy falls -> TURN 16 cycles -> IDLE -> REQ again since tx_req still high.
- Timeout with CTS_TIMEOUT=100, FD, tx_req=1, cts_n_i=1: cts_timeout_o pulses for 1 cycle every 100 cycles. hwfc_en_i=0 -> no pulse, grant=1.
- Reset: assert rst during HD_TX -> next cycle rts_n_o=1, all enables/grant 0, FSM HD_IDLE. SIMPLEX slave after reset -> rx_en=1, tx_en=0, grant=0.

Source files
------------

// File: rtl/uart_flow_ctrl_hd_pkg.sv
// Shared types and default constants for the half-duplex RTS/CTS flow controller.
package uart_flow_ctrl_hd_pkg;

  typedef enum logic [1:0] {
    FULLDUPLEX = 2'd0,
    HALFDUPLEX = 2'd1,
    SIMPLEX    = 2'd2
  } UartMode_t;

  typedef struct packed {
    UartMode_t mode;
    logic      master;
  } Config_t;

  typedef enum logic [2:0] {
    HD_IDLE = 3'd0,
    HD_REQ  = 3'd1,
    HD_TX   = 3'd2,
    HD_RX   = 3'd3,
    HD_TURN = 3'd4
  } FCHdState_t;

  localparam int unsigned DEF_FIFO_DEPTH  = 16;
  localparam int unsigned DEF_RTS_HI_WM   = 12;
  localparam int unsigned DEF_RTS_LO_WM   = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_TURN_CYC    = 16;
  localparam int unsigned DEF_CTS_TIMEOUT = 65535;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_flow_ctrl_hd_sync.sv
// Generic single-bit multi-flop synchroniser with a configurable reset value.
module uart_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic tck,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge tck) begin
    if (rst) r_sync <= {STAGES{RST_VAL}};
    else     r_sync <= {r_sync[STAGES-2:0], d_i};
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/uart_flow_ctrl_hd.sv
// RTS/CTS flow control with RX watermark hysteresis, half-duplex direction
// FSM with turnaround guard, CTS-blocked timeout and flow-control bypass.
//
// state   | meaning
// HD_IDLE | line quiet, listening; rts_n released
// HD_REQ  | local side asserts rts_n, waiting for CTS
// HD_TX   | local transmitter owns the line
// HD_RX   | remote transmitter owns the line
// HD_TURN | guard time, both directions disabled
//
// Outputs are registered from the next-state decode, so they always line up
// with the registered state. A collision (remote starts while requesting)
// releases rts_n for the first RX cycle before it follows the watermark.
module uart_flow_ctrl_hd
  import uart_flow_ctrl_hd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned RTS_HI_WM   = DEF_RTS_HI_WM,
  parameter int unsigned RTS_LO_WM   = DEF_RTS_LO_WM,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned TURN_CYC    = DEF_TURN_CYC,
  parameter int unsigned CTS_TIMEOUT = DEF_CTS_TIMEOUT,
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             tck,
  input  logic             rst,
  input  logic             cts_n_i,
  output logic             rts_n_o,
  input  logic [LVL_W-1:0] rx_level_i,
  input  logic             rx_busy_i,
  input  logic             tx_req_i,
  input  logic             tx_busy_i,
  output logic             tx_grant_o,
  output logic             tx_enable_o,
  output logic             rx_enable_o,
  input  logic             hwfc_en_i,
  output logic             cts_timeout_o,
  input  Config_t          uart_config_i
);

  localparam int unsigned TC_W = cnt_width(TURN_CYC);

  FCHdState_t      r_state, w_state_nxt;
  logic [TC_W-1:0] r_turn_cnt;
  logic            r_rx_stop, w_rx_stop_nxt;
  logic            r_rts_n, r_grant, r_tx_en, r_rx_en;
  logic            w_rts_n, w_grant, w_tx_en, w_rx_en;
  logic            w_cts_s, w_cts_ok, w_rts_rx, w_collide, w_tx_ctx;
  logic            w_turn_last, w_to_inc;

  uart_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cts_sync (
    .tck (tck),
    .rst (rst),
    .d_i (cts_n_i),
    .q_o (w_cts_s)
  );

  assign w_cts_ok    = !hwfc_en_i || !w_cts_s;
  assign w_turn_last = (r_turn_cnt == TC_W'(TURN_CYC - 1));
  assign w_to_inc    = w_tx_ctx && tx_req_i && !w_cts_ok;

  // Watermark hysteresis; the pin follows the next value for one-cycle latency.
  always_comb begin
    w_rx_stop_nxt = r_rx_stop;
    if (rx_level_i >= LVL_W'(RTS_HI_WM))      w_rx_stop_nxt = 1'b1;
    else if (rx_level_i <= LVL_W'(RTS_LO_WM)) w_rx_stop_nxt = 1'b0;
  end

  assign w_rts_rx = hwfc_en_i && w_rx_stop_nxt;

  // Next-state and output decode for all modes.
  always_comb begin
    w_state_nxt = HD_IDLE;
    w_rts_n     = 1'b1;
    w_grant     = 1'b0;
    w_tx_en     = 1'b0;
    w_rx_en     = 1'b0;
    w_collide   = 1'b0;
    w_tx_ctx    = 1'b0;
    if (uart_config_i.mode == HALFDUPLEX) begin
      w_tx_ctx    = (r_state == HD_REQ) || (r_state == HD_TX);
      w_state_nxt = r_state;
      case (r_state)
        HD_IDLE: begin
          if (rx_busy_i)     w_state_nxt = HD_RX;
          else if (tx_req_i) w_state_nxt = HD_REQ;
        end
        HD_REQ: begin
          if (rx_busy_i) begin
            w_state_nxt = HD_RX;
            w_collide   = 1'b1;
          end else if (w_cts_ok) w_state_nxt = HD_TX;
          else if (!tx_req_i)    w_state_nxt = HD_IDLE;
        end
        HD_TX:   if (!tx_req_i && !tx_busy_i) w_state_nxt = HD_TURN;
        HD_RX:   if (!rx_busy_i) w_state_nxt = HD_TURN;
        HD_TURN: if (w_turn_last) w_state_nxt = HD_IDLE;
        default: w_state_nxt = HD_IDLE;
      endcase
      case (w_state_nxt)
        HD_IDLE: w_rx_en = 1'b1;
        HD_REQ: begin
          w_rx_en = 1'b1;
          w_rts_n = 1'b0;
        end
        HD_TX: begin
          w_tx_en = 1'b1;
          w_rts_n = 1'b0;
          w_grant = tx_req_i && w_cts_ok;
        end
        HD_RX: begin
          w_rx_en = 1'b1;
          w_rts_n = w_collide ? 1'b1 : w_rts_rx;
        end
        default: ;
      endcase
    end else if (uart_config_i.mode == SIMPLEX) begin
      if (uart_config_i.master) begin
        w_tx_en  = 1'b1;
        w_grant  = tx_req_i && w_cts_ok;
        w_tx_ctx = 1'b1;
      end else begin
        w_rx_en = 1'b1;
        w_rts_n = w_rts_rx;
      end
    end else begin
      w_tx_en  = 1'b1;
      w_rx_en  = 1'b1;
      w_rts_n  = w_rts_rx;
      w_grant  = tx_req_i && w_cts_ok;
      w_tx_ctx = 1'b1;
    end
  end

  // State, hysteresis flag and registered outputs.
  always_ff @(posedge tck) begin
    if (rst) begin
      r_state   <= HD_IDLE;
      r_rx_stop <= 1'b0;
      r_rts_n   <= 1'b1;
      r_grant   <= 1'b0;
      r_tx_en   <= 1'b0;
      r_rx_en   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rx_stop <= w_rx_stop_nxt;
      r_rts_n   <= w_rts_n;
      r_grant   <= w_grant;
      r_tx_en   <= w_tx_en;
      r_rx_en   <= w_rx_en;
    end
  end

  // Turnaround guard: counts only while staying in HD_TURN.
  always_ff @(posedge tck) begin
    if (rst) r_turn_cnt <= '0;
    else if ((r_state == HD_TURN) && (w_state_nxt == HD_TURN)) r_turn_cnt <= r_turn_cnt + 1'b1;
    else r_turn_cnt <= '0;
  end

  generate
    if (CTS_TIMEOUT > 0) begin : g_to
      localparam int unsigned TO_W = cnt_width(CTS_TIMEOUT);
      logic [TO_W-1:0] r_to_cnt;
      logic            r_to_pulse;

      // Blocked-TX counter; wraps to zero with a one-cycle pulse.
      always_ff @(posedge tck) begin
        if (rst || !w_to_inc) begin
          r_to_cnt   <= '0;
          r_to_pulse <= 1'b0;
        end else if (r_to_cnt == TO_W'(CTS_TIMEOUT - 1)) begin
          r_to_cnt   <= '0;
          r_to_pulse <= 1'b1;
        end else begin
          r_to_cnt   <= r_to_cnt + 1'b1;
          r_to_pulse <= 1'b0;
        end
      end

      assign cts_timeout_o = r_to_pulse;
    end else begin : g_no_to
      assign cts_timeout_o = 1'b0;
    end
  endgenerate

  assign rts_n_o     = r_rts_n;
  assign tx_grant_o  = r_grant;
  assign tx_enable_o = r_tx_en;
  assign rx_enable_o = r_rx_en;

endmodule

// File: tb/tb_uart_flow_ctrl_hd.sv
// Scoreboard bench: the driver pushes one hand-computed output vector per
// clock, a negedge monitor pops and compares against the DUT outputs.
// Vector order: {rts_n, tx_grant, tx_enable, rx_enable, cts_timeout}.
module tb_uart_flow_ctrl_hd;
  import uart_flow_ctrl_hd_pkg::*;

  typedef struct {
    logic [4:0] exp;
    string      nm;
  } sb_t;

  logic       tck = 1'b0;
  logic       rst, cts_n, rts_n, rx_busy, tx_req, tx_busy;
  logic       grant, tx_en, rx_en, hwfc, to_pulse;
  logic [4:0] rx_level;
  Config_t    cfg;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  uart_flow_ctrl_hd #(.CTS_TIMEOUT(100)) dut (
    .tck           (tck),
    .rst           (rst),
    .cts_n_i       (cts_n),
    .rts_n_o       (rts_n),
    .rx_level_i    (rx_level),
    .rx_busy_i     (rx_busy),
    .tx_req_i      (tx_req),
    .tx_busy_i     (tx_busy),
    .tx_grant_o    (grant),
    .tx_enable_o   (tx_en),
    .rx_enable_o   (rx_en),
    .hwfc_en_i     (hwfc),
    .cts_timeout_o (to_pulse),
    .uart_config_i (cfg)
  );

  always #5 tck = ~tck;

  // Monitor: compare the outputs against the oldest expectation.
  always @(negedge tck) begin
    if (sb.size() > 0) begin
      sb_t  e;
      logic [4:0] act;
      e   = sb.pop_front();
      act = {rts_n, grant, tx_en, rx_en, to_pulse};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got rts_n/grant/tx_en/rx_en/to=%b expected %b at %0t", e.nm, act, e.exp, $time);
      end
    end
  end

  task automatic step(input logic [4:0] exp, input string nm);
    sb_t e;
    @(posedge tck);
    #1;
    e.exp = exp;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic turn16(input string nm);
    for (int i = 0; i < 16; i++) step(5'b10000, nm);
  endtask

  initial begin
    rst = 1'b1; cts_n = 1'b1; rx_level = '0; rx_busy = 1'b0;
    tx_req = 1'b0; tx_busy = 1'b0; hwfc = 1'b1;
    cfg.mode = FULLDUPLEX; cfg.master = 1'b0;

    step(5'b10000, "reset0");
    step(5'b10000, "reset1");

    // Full duplex, CTS through the synchroniser
    rst = 1'b0; tx_req = 1'b1;
    step(5'b00110, "fd_blocked");
    cts_n = 1'b0;
    step(5'b00110, "fd_cts_lat1");
    step(5'b00110, "fd_cts_lat2");
    step(5'b01110, "fd_cts_grant");
    step(5'b01110, "fd_grant_hold");
    tx_busy = 1'b1; cts_n = 1'b1;
    step(5'b01110, "fd_cts_off1");
    step(5'b01110, "fd_cts_off2");
    step(5'b00110, "fd_cts_off3");
    tx_req = 1'b0; tx_busy = 1'b0;
    step(5'b00110, "fd_done");

    // Watermark hysteresis
    rx_level = 5'd11; step(5'b00110, "wm_11");
    rx_level = 5'd12; step(5'b10110, "wm_12");
    rx_level = 5'd5;  step(5'b10110, "wm_5_hold");
    rx_level = 5'd4;  step(5'b00110, "wm_4_release");
    rx_level = 5'd12; step(5'b10110, "wm_12_again");
    rx_level = 5'd8;  step(5'b10110, "wm_8_hold");
    hwfc = 1'b0;      step(5'b00110, "wm_bypass");
    hwfc = 1'b1;      step(5'b10110, "wm_hwfc_back");
    rx_level = 5'd0;  step(5'b00110, "wm_0");

    // Half duplex TX path with turnaround
    cts_n = 1'b0;
    step(5'b00110, "fd_cts_settle1");
    step(5'b00110, "fd_cts_settle2");
    cfg.mode = HALFDUPLEX;
    step(5'b10010, "hd_idle");
    tx_req = 1'b1;
    step(5'b00010, "hd_req");
    step(5'b01100, "hd_tx");
    tx_busy = 1'b1;
    step(5'b01100, "hd_tx_busy");
    tx_req = 1'b0;
    step(5'b00100, "hd_tx_drain");
    tx_busy = 1'b0;
    turn16("hd_turn_tx");
    step(5'b10010, "hd_turn_to_idle");

    // Half duplex collision
    cts_n = 1'b1;
    step(5'b10010, "hd_idle_cts1");
    step(5'b10010, "hd_idle_cts2");
    tx_req = 1'b1;
    step(5'b00010, "hd_req_blk1");
    step(5'b00010, "hd_req_blk2");
    rx_busy = 1'b1;
    step(5'b10010, "hd_collide");
    step(5'b00010, "hd_rx");
    rx_busy = 1'b0;
    turn16("hd_turn_rx");
    step(5'b10010, "hd_idle_after_rx");
    step(5'b00010, "hd_req_again");
    tx_req = 1'b0;
    step(5'b10010, "hd_req_abandon");

    // Reset during HD_TX, then simplex
    cts_n = 1'b0;
    step(5'b10010, "hd_cts_settle1");
    step(5'b10010, "hd_cts_settle2");
    tx_req = 1'b1;
    step(5'b00010, "hd_req2");
    step(5'b01100, "hd_tx2");
    rst = 1'b1;
    step(5'b10000, "rst_mid_tx");
    rst = 1'b0; cfg.mode = SIMPLEX; cfg.master = 1'b0;
    step(5'b00010, "sx_slave");
    cfg.master = 1'b1;
    step(5'b10100, "sx_master_blk");
    step(5'b11100, "sx_master_grant");

    // CTS timeout every 100 blocked cycles, then bypass
    rst = 1'b1;
    step(5'b10000, "reset_to");
    rst = 1'b0; cfg.mode = FULLDUPLEX; cts_n = 1'b1; tx_req = 1'b1; hwfc = 1'b1;
    for (int k = 1; k <= 250; k++)
      step({4'b0011, (k % 100 == 0)}, "to_pulse");
    hwfc = 1'b0;
    for (int k = 0; k < 150; k++)
      step(5'b01110, "to_bypass");

    @(negedge tck);
    @(negedge tck);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
